// File: rtl/matdet6_seq.sv
// rtl/matdet6_seq.sv - sequential 6x6 determinant by cofactor expansion along row 0
//
// Purpose:
//   Computes det(M) mod 2^DATA_WIDTH for a 6x6 matrix, one row-0 column per cycle.
//   A single combinational 5x5 minor determinant and a single multiplier are shared
//   across the six columns; the running sum lives in acc_q.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   matrix on in_mat is valid
//   in_ready   out  block accepts a matrix (IDLE only)
//   in_mat     in   element (r,c) at bits [DATA_WIDTH*(6r+c) +: DATA_WIDTH]
//   out_valid  out  det holds a completed result (DONE)
//   out_ready  in   consumer takes det
//   det        out  determinant mod 2^DATA_WIDTH; holds last result outside DONE
//   busy       out  high in RUN or DONE
//
// Configuration macro:
//   MATDET6_SEQ_ZERO_SKIP_EN  when defined, RUN visits only columns whose row-0
//                             element is nonzero; an all-zero row 0 goes straight
//                             to DONE with a zero result.

module matdet6_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int MATRIX_SIZE = 36
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] in_mat,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             det,
    output logic                              busy
);

    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                col_q, col_d;
    logic [W-1:0]              acc_q, acc_d;
    logic [W-1:0]              det_q, det_d;
    logic [MATRIX_SIZE*W-1:0]  mat_q, mat_d;

    logic [25*W-1:0]           minor_bus;
    logic [24:0][W-1:0]        minor_arr;
    logic [W-1:0]              minor_det;
    logic [W-1:0]              m0;
    logic [W-1:0]              term;

    // ------------------------------------------------------------------
    // Minor determinant helpers. Arrays are row-major with element index
    // 0 in the lowest slice. All arithmetic truncates to W bits, so every
    // intermediate is already reduced mod 2^W.
    // ------------------------------------------------------------------
    function automatic logic [W-1:0] det3(input logic [8:0][W-1:0] a);
        det3 = a[0] * (a[4] * a[8] - a[5] * a[7])
             - a[1] * (a[3] * a[8] - a[5] * a[6])
             + a[2] * (a[3] * a[7] - a[4] * a[6]);
    endfunction

    function automatic logic [W-1:0] det4(input logic [15:0][W-1:0] a);
        logic [8:0][W-1:0] s;
        logic [W-1:0]      sum;
        sum = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 1; r < 4; r++) begin
                for (int j = 0; j < 3; j++) begin
                    s[3*(r-1)+j] = a[4*r + ((j < c) ? j : j + 1)];
                end
            end
            if ((c % 2) == 1) sum = sum - a[c] * det3(s);
            else              sum = sum + a[c] * det3(s);
        end
        det4 = sum;
    endfunction

    function automatic logic [W-1:0] det5(input logic [24:0][W-1:0] a);
        logic [15:0][W-1:0] s;
        logic [W-1:0]       sum;
        sum = '0;
        for (int c = 0; c < 5; c++) begin
            for (int r = 1; r < 5; r++) begin
                for (int j = 0; j < 4; j++) begin
                    s[4*(r-1)+j] = a[5*r + ((j < c) ? j : j + 1)];
                end
            end
            if ((c % 2) == 1) sum = sum - a[c] * det4(s);
            else              sum = sum + a[c] * det4(s);
        end
        det5 = sum;
    endfunction

`ifdef MATDET6_SEQ_ZERO_SKIP_EN
    // Lowest column >= start whose row-0 element is nonzero; 6 when none remain.
    function automatic logic [3:0] next_nz(input logic [6*W-1:0] row0,
                                           input logic [3:0]     start);
        next_nz = 4'd6;
        for (int k = 5; k >= 0; k--) begin
            if (k >= int'(start) && row0[W*k +: W] != '0) next_nz = 4'(k);
        end
    endfunction

    logic [3:0] nz_first;
    logic [3:0] nz_next;
    assign nz_first = next_nz(in_mat[6*W-1:0], 4'd0);
    assign nz_next  = next_nz(mat_q[6*W-1:0], 4'(col_q) + 4'd1);
`endif

    // ------------------------------------------------------------------
    // Minor of column col_q: rows 1..5 with column col_q removed, listed
    // row-major, first listed element in the most-significant slice.
    // ------------------------------------------------------------------
    always_comb begin
        minor_bus = '0;
        for (int r = 1; r < 6; r++) begin
            for (int j = 0; j < 5; j++) begin
                minor_bus[W*(24 - (5*(r-1) + j)) +: W] =
                    mat_q[W*(6*r + j + ((j >= int'(col_q)) ? 1 : 0)) +: W];
            end
        end
    end

    always_comb begin
        minor_arr = '0;
        for (int i = 0; i < 25; i++) begin
            minor_arr[i] = minor_bus[W*(24 - i) +: W];
        end
    end

    assign minor_det = det5(minor_arr);
    assign m0        = mat_q[W*int'(col_q) +: W];
    assign term      = m0 * minor_det;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef MATDET6_SEQ_ZERO_SKIP_EN
                    state_d = (nz_first == 4'd6) ? ST_DONE : ST_RUN;
`else
                    state_d = ST_RUN;
`endif
                end
            end
            ST_RUN: begin
`ifdef MATDET6_SEQ_ZERO_SKIP_EN
                if (nz_next == 4'd6) state_d = ST_DONE;
`else
                if (col_q == 3'd5) state_d = ST_DONE;
`endif
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        det       = det_q;
    end

    // ------------------------------------------------------------------
    // Datapath next-state. det_q is only loaded on entry to DONE so that
    // the partial sum never shows on det while RUN is in progress.
    // ------------------------------------------------------------------
    always_comb begin
        mat_d = mat_q;
        col_d = col_q;
        acc_d = acc_q;
        det_d = det_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mat_d = in_mat;
                    acc_d = '0;
                    col_d = 3'd0;
`ifdef MATDET6_SEQ_ZERO_SKIP_EN
                    if (nz_first == 4'd6) det_d = '0;
                    else                  col_d = nz_first[2:0];
`endif
                end
            end
            ST_RUN: begin
                acc_d = col_q[0] ? (acc_q - term) : (acc_q + term);
`ifdef MATDET6_SEQ_ZERO_SKIP_EN
                if (nz_next == 4'd6) det_d = acc_d;
                else                 col_d = nz_next[2:0];
`else
                if (col_q == 3'd5) det_d = acc_d;
                else               col_d = col_q + 3'd1;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= 3'd0;
            acc_q <= '0;
            det_q <= '0;
            mat_q <= '0;
        end else begin
            col_q <= col_d;
            acc_q <= acc_d;
            det_q <= det_d;
            mat_q <= mat_d;
        end
    end

endmodule

// File: tb/tb_matdet6_seq.sv
// tb/tb_matdet6_seq.sv - self-checking bench for matdet6_seq against a Leibniz-formula model

module tb_matdet6_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [287:0] in_mat = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   det;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int ref_m[6][6];

    matdet6_seq #(.DATA_WIDTH(8), .MATRIX_SIZE(36)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mat    (in_mat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .det       (det),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [287:0] pack_ref();
        logic [287:0] p;
        p = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                p[W*(6*r+c) +: W] = 8'(ref_m[r][c]);
        return p;
    endfunction

    // Sum over all 720 permutations, sign from inversion parity, mod 256.
    function automatic int ref_det();
        int total, t, used, inv, prod;
        int p[6];
        bit ok;
        total = 0;
        for (int n = 0; n < 46656; n++) begin
            t = n; used = 0; ok = 1'b1;
            for (int i = 0; i < 6; i++) begin
                p[i] = t % 6;
                t = t / 6;
                if ((used & (1 << p[i])) != 0) ok = 1'b0;
                used = used | (1 << p[i]);
            end
            if (ok) begin
                inv = 0; prod = 1;
                for (int i = 0; i < 6; i++)
                    for (int j = i + 1; j < 6; j++)
                        if (p[i] > p[j]) inv++;
                for (int i = 0; i < 6; i++)
                    prod = (prod * (ref_m[i][p[i]] & 255)) & 255;
                if ((inv % 2) == 1) total = total - prod;
                else                total = total + prod;
            end
        end
        return total & 255;
    endfunction

    function automatic int nnz_ref();
        int n;
        n = 0;
        for (int c = 0; c < 6; c++) if ((ref_m[0][c] & 255) != 0) n++;
        return n;
    endfunction

    function automatic int exp_lat(input int nz);
`ifdef MATDET6_SEQ_ZERO_SKIP_EN
        return nz;
`else
        return 6 + 0 * nz;
`endif
    endfunction

    task automatic set_diag(input int v);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                ref_m[r][c] = (r == c) ? v : 0;
    endtask

    task automatic set_random(input bool_zero);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++)
                ref_m[r][c] = $urandom_range(0, 255);
        for (int c = 0; c < 6; c++) begin
            if (bool_zero && $urandom_range(0, 2) == 0) ref_m[0][c] = 0;
            if (!bool_zero && ref_m[0][c] == 0) ref_m[0][c] = 1;
        end
    endtask

    // ---------------- stimulus helpers (called at posedge+1) ----------------
    task automatic send(output int lat, output int acc_cyc, output bit to);
        int guard;
        guard = 0;
        to = 1'b0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        in_mat   = pack_ref();
        in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) to = 1'b1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (det !== 8'h00)      begin n_fail++; $display("FAIL reset_det got %h want 00", det); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_identity();
        int lat, ac; bit to;
        set_diag(1);
        out_ready = 1'b1;
        send(lat, ac, to);
        n_tests++; if (to !== 1'b0)         begin n_fail++; $display("FAIL ident_timeout no out_valid"); end
        n_tests++; if (lat != exp_lat(1))   begin n_fail++; $display("FAIL ident_latency got %0d want %0d", lat, exp_lat(1)); end
        n_tests++; if (det !== 8'h01)       begin n_fail++; $display("FAIL ident_det got %h want 01", det); end
        n_tests++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL ident_in_ready_done got %b want 0", in_ready); end
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL ident_one_cycle out_valid got %b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL ident_in_ready_e8 got %b want 1", in_ready); end
        n_tests++; if (det !== 8'h01)       begin n_fail++; $display("FAIL ident_det_hold got %h want 01", det); end
        out_ready = 1'b0;
    endtask

    task automatic test_known();
        int lat, ac, want, nz; bit to;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin set_diag(1); ref_m[0][0] = 0; ref_m[0][1] = 1; ref_m[1][0] = 1; ref_m[1][1] = 0; want = 8'hFF; end
                1: begin set_diag(3); want = 8'hD9; end
                2: begin set_diag(2); want = 8'h40; end
                3: begin set_diag(1); ref_m[0][0] = 0; want = 8'h00; end
                default: begin
                    set_random(1'b0);
                    for (int c = 0; c < 6; c++) ref_m[0][c] = 0;
                    ref_m[0][0] = 1; ref_m[0][2] = 2;
                    want = ref_det();
                end
            endcase
            nz = nnz_ref();
            send(lat, ac, to);
            n_tests++; if (to !== 1'b0)       begin n_fail++; $display("FAIL known%0d_timeout no out_valid", k); end
            n_tests++; if (det !== 8'(want))  begin n_fail++; $display("FAIL known%0d_det got %h want %h", k, det, 8'(want)); end
            n_tests++; if (lat != exp_lat(nz)) begin n_fail++; $display("FAIL known%0d_latency got %0d want %0d", k, lat, exp_lat(nz)); end
            drain();
        end
    endtask

    task automatic test_random();
        int lat, ac, want, nz, stall; bit to;
        for (int k = 0; k < 12; k++) begin
            set_random(1'b1);
            want = ref_det();
            nz = nnz_ref();
            stall = $urandom_range(0, 3);
            send(lat, ac, to);
            n_tests++; if (to !== 1'b0)        begin n_fail++; $display("FAIL rand%0d_timeout no out_valid", k); end
            n_tests++; if (lat != exp_lat(nz)) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", k, lat, exp_lat(nz)); end
            for (int s = 0; s <= stall; s++) begin
                n_tests++; if (det !== 8'(want) || out_valid !== 1'b1)
                    begin n_fail++; $display("FAIL rand%0d_det got %h/%b want %h/1", k, det, out_valid, 8'(want)); end
                if (s < stall) begin @(posedge clk); #1; end
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        int lat, ac; bit to;
        set_diag(1);
        send(lat, ac, to);
        set_diag(2);
        in_mat   = pack_ref();
        in_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            n_tests++; if (out_valid !== 1'b1 || det !== 8'h01 || in_ready !== 1'b0)
                begin n_fail++; $display("FAIL bp_hold%0d got ov=%b det=%h ir=%b want 1/01/0", s, out_valid, det, in_ready); end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
            begin n_fail++; $display("FAIL bp_release got ov=%b ir=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
        n_tests++; if (det !== 8'h01) begin n_fail++; $display("FAIL bp_det_kept got %h want 01", det); end
    endtask

    task automatic test_reset_mid();
        int lat, ac, want; bit to;
        set_random(1'b0);
        in_mat   = pack_ref();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || det !== 8'h00 || busy !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_async got ov=%b ir=%b det=%h busy=%b want 0/1/00/0", out_valid, in_ready, det, busy); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_idle got ov=%b busy=%b want 0/0", out_valid, busy); end
        set_random(1'b1);
        want = ref_det();
        send(lat, ac, to);
        n_tests++; if (to !== 1'b0 || det !== 8'(want))
            begin n_fail++; $display("FAIL rstmid_after got %h to=%b want %h", det, to, 8'(want)); end
        drain();
    endtask

    task automatic test_back_to_back();
        int lat, ac1, ac2, want; bit to;
        out_ready = 1'b1;
        set_random(1'b0);
        want = ref_det();
        send(lat, ac1, to);
        n_tests++; if (to !== 1'b0 || det !== 8'(want))
            begin n_fail++; $display("FAIL b2b_first got %h want %h", det, 8'(want)); end
        set_random(1'b0);
        want = ref_det();
        send(lat, ac2, to);
        n_tests++; if (to !== 1'b0 || det !== 8'(want))
            begin n_fail++; $display("FAIL b2b_second got %h want %h", det, 8'(want)); end
        n_tests++; if (ac2 - ac1 != 8)
            begin n_fail++; $display("FAIL b2b_spacing got %0d want 8", ac2 - ac1); end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_known();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
